gen_step_engine: RTL
====================

Name: gen_step_engine

Overview:
- Computes one Game of Life generation: scans every cell of the current-field memory and writes each cell's next state into the next-field memory.
- Acts as the reader/consumer of neighbour addresses. Per cell it uses the existing get_nbrs_address block to obtain the 8 neighbour addresses and relevance flags, issues the reads, counts live neighbours and applies the rule.
- Sits between the top-level generation controller (start/done handshake) and the two field RAMs (1-cycle synchronous read, synchronous write).

Parameters:
- FIELD_W, 16, field width in cells (>=2)
- FIELD_H, 16, field height in cells (>=2)
- BIRTH_MASK, 9'b000001000, bit n set = dead cell with n live neighbours becomes alive (B3)
- SURVIVE_MASK, 9'b000001100, bit n set = live cell with n live neighbours stays alive (S23)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  start one generation; sampled only in IDLE
- o_busy  output  1  high from the cycle after start is accepted through the WRITE of the last cell
- o_done  output  1  one-cycle pulse when the generation completes
- o_changed  output  1  at least one cell differed from its previous state in the last generation; valid when o_done is high, held until the next start
- o_rd_en  output  1  current-field read enable
- o_rd_x_adr  output  $clog2(FIELD_W)  read x address
- o_rd_y_adr  output  $clog2(FIELD_H)  read y address
- i_rd_data  input  1  cell state; valid the cycle after o_rd_en
- o_wr_en  output  1  next-field write enable
- o_wr_x_adr  output  $clog2(FIELD_W)  write x address
- o_wr_y_adr  output  $clog2(FIELD_H)  write y address
- o_wr_data  output  1  next state of the cell

Behaviour:
- Reset: async assert forces IDLE. All outputs are 0, the cell pointer is (0,0), the count is 0 and o_changed is 0. A reset mid-generation aborts with no further write and no o_done. Deassertion is synchronised by the usual 2-flop scheme.
- States: IDLE, READ, LAST, WRITE, DONE.
- IDLE: when i_start=1, clear o_changed and the cell pointer, then go to READ. Otherwise stay.
- READ: slot counter k runs 0..8, one cycle per slot.
  - k=0 reads the cell itself.
  - k=1..8 reads neighbour k-1 in get_nbrs_address numbering (0 1 2 / 3 x 4 / 5 6 7).
  - For an irrelevant neighbour (field edge, no wrap-around), o_rd_en=0, addresses are held at the cell's own and the returned data is treated as 0.
  - Data from slot k-1 is captured in the slot-k cycle.
  - After k=8, go to LAST.
- LAST: capture slot-8 data and go to WRITE.
- Neighbour count: 4-bit unsigned, range 0..8, never overflows.
- WRITE:
  - Drive o_wr_en=1 with the cell address.
  - o_wr_data = self ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt].
  - If o_wr_data != self, set o_changed.
  - Clear the count.
  - Advance the pointer: x increments; when x wraps from FIELD_W-1 to 0, y increments.
  - After the last cell (FIELD_W-1, FIELD_H-1), go to DONE; otherwise return to READ with k=0.
- Cost: exactly 11 cycles per cell, so a generation takes FIELD_W*FIELD_H*11 cycles.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE. i_start in DONE is ignored.
- i_start while busy is ignored and has no effect on the running scan.
- The current-field memory is never written. Each cell of the next field is written exactly once per generation, in raster order.

Test Plan (FIELD_W=FIELD_H=4, default masks unless stated):
- Empty field, i_start pulse at cycle 0: o_done high exactly at cycle 177; 16 writes all with data 0; o_changed=0; no read ever issued outside the field.
- Vertical blinker at (1,0),(1,1),(1,2): next field alive exactly at (0,1),(1,1),(2,1); o_changed=1. A second generation restores the original pattern.
- 2x2 block at (1,1)-(2,2): next field identical; o_changed=0.
- Corner cell (0,0) scan: o_rd_en low in slots 1,2,3,4,6 (neighbours 0,1,2,3,5); cell (3,3): o_rd_en low in slots 3,5,6,7,8 (neighbours 2,4,5,6,7).
- Reset asserted at cycle 60 mid-scan: all outputs 0 immediately, no o_done. A new i_start after release gives a full 177-cycle generation from (0,0).
- i_start held high for the whole generation: exactly one generation runs, with one o_done. Then, with i_start still high in IDLE, a new generation starts.
- All-alive field with SURVIVE_MASK=9'b111111111: every write is 1 (corner count 3, edge count 5, interior count 8); o_changed=0.

Source files
------------

// File: rtl/gen_step_engine.sv
// gen_step_engine: one Game of Life generation, raster scan of current field into next field, 11 cycles per cell
module gen_step_engine #(
    parameter int FIELD_W = 16,
    parameter int FIELD_H = 16,
    parameter logic [8:0] BIRTH_MASK = 9'b000001000,
    parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_changed,
    output logic                         o_rd_en,
    output logic [$clog2(FIELD_W)-1:0]   o_rd_x_adr,
    output logic [$clog2(FIELD_H)-1:0]   o_rd_y_adr,
    input  logic                         i_rd_data,
    output logic                         o_wr_en,
    output logic [$clog2(FIELD_W)-1:0]   o_wr_x_adr,
    output logic [$clog2(FIELD_H)-1:0]   o_wr_y_adr,
    output logic                         o_wr_data
);
    localparam int XW = $clog2(FIELD_W);
    localparam int YW = $clog2(FIELD_H);
    localparam logic [XW-1:0] XMAX = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(FIELD_H - 1);
    localparam logic [15:0] BM = {7'b0, BIRTH_MASK};
    localparam logic [15:0] SM = {7'b0, SURVIVE_MASK};

    typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    k, cnt;
    logic          self, rd_en_q, changed;
    logic [2:0]    n;
    logic          xm, xp, ym, yp, rel, last_cell;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) rst_sync <= 2'b00;
        else rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n = rst_sync[1];

    // slot k>0 addresses neighbour k-1: 0 1 2 / 3 x 4 / 5 6 7
    assign n  = k[2:0] - 3'd1;
    assign xm = k != 4'd0 && (n == 3'd0 || n == 3'd3 || n == 3'd5);
    assign xp = k != 4'd0 && (n == 3'd2 || n == 3'd4 || n == 3'd7);
    assign ym = k != 4'd0 && n <= 3'd2;
    assign yp = k != 4'd0 && n >= 3'd5;
    assign rel = !((xm && x == '0) || (xp && x == XMAX) || (ym && y == '0) || (yp && y == YMAX));
    assign last_cell = x == XMAX && y == YMAX;

    assign o_busy     = state == READ || state == LAST || state == WRITE;
    assign o_done     = state == DONE;
    assign o_changed  = changed;
    assign o_rd_en    = state == READ && rel;
    assign o_rd_x_adr = !o_rd_en ? x : xm ? x - XW'(1) : xp ? x + XW'(1) : x;
    assign o_rd_y_adr = !o_rd_en ? y : ym ? y - YW'(1) : yp ? y + YW'(1) : y;
    assign o_wr_en    = state == WRITE;
    assign o_wr_x_adr = x;
    assign o_wr_y_adr = y;
    assign o_wr_data  = state == WRITE && (self ? SM[cnt] : BM[cnt]);

    always_ff @(posedge i_clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_start ? READ : IDLE;
            READ:    state_nxt = k == 4'd8 ? LAST : READ;
            LAST:    state_nxt = WRITE;
            WRITE:   state_nxt = last_cell ? DONE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n)
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            k       <= '0;
            cnt     <= '0;
            self    <= 1'b0;
            rd_en_q <= 1'b0;
            changed <= 1'b0;
        end else begin
            rd_en_q <= o_rd_en;
            case (state)
                IDLE: if (i_start) begin
                    x       <= '0;
                    y       <= '0;
                    k       <= '0;
                    cnt     <= '0;
                    changed <= 1'b0;
                end
                READ: begin
                    k <= k + 4'd1;
                    if (k == 4'd1) self <= i_rd_data;
                    else if (k >= 4'd2) cnt <= cnt + {3'b0, rd_en_q & i_rd_data};
                end
                LAST: cnt <= cnt + {3'b0, rd_en_q & i_rd_data};
                WRITE: begin
                    if (o_wr_data != self) changed <= 1'b1;
                    cnt <= '0;
                    k   <= '0;
                    x   <= x == XMAX ? '0 : x + XW'(1);
                    if (x == XMAX) y <= y == YMAX ? '0 : y + YW'(1);
                end
                default: ;
            endcase
        end
endmodule
